// File: rtl/skyline_layer_if.sv
// Timing-to-layer link for one skyline layer: raster strobes in, per-pixel hit/border out.
// master is the timing side; slave is the layer.
interface skyline_layer_if;
   logic       visible;
   logic       line_start;
   logic       frame_start;
   logic [9:0] vcount;
   logic       hit;
   logic       border;

   modport master (
      output visible,
      output line_start,
      output frame_start,
      output vcount,
      input  hit,
      input  border
   );

   modport slave (
      input  visible,
      input  line_start,
      input  frame_start,
      input  vcount,
      output hit,
      output border
   );
endinterface

// File: rtl/skyline_layer.sv
// One parallax skyline layer: pseudo-random column heights from a 9-bit LFSR,
// scrolled horizontally by a per-frame sub-counter, producing registered hit/border.
module skyline_layer #(
   parameter int unsigned COL_W_LOG2 = 3,
   parameter int unsigned ROW_H_LOG2 = 4,
   parameter int unsigned TOP_LINE   = 112,
   parameter int unsigned SPEED_LOG2 = 0,
   parameter logic [8:0]  SEED       = 9'h1FF
) (
   input  logic          clk,
   input  logic          rst,
   skyline_layer_if.slave lyr
);

   localparam int unsigned SUB_W = (SPEED_LOG2 > 0) ? SPEED_LOG2 : 1;
   localparam logic [9:0]  TOP   = 10'(TOP_LINE);

   logic [8:0]            lfsr;
   logic [8:0]            lfsr_b;
   logic [COL_W_LOG2-1:0] col;
   logic [COL_W_LOG2-1:0] col_b;
   logic [SUB_W-1:0]      sub;
   logic [4:0]            cutoff;
   logic                  row_edge;
   logic                  hit_q;
   logic                  border_q;

   logic [9:0]            d;
   logic [9:0]            rows;
   logic [ROW_H_LOG2-1:0] roff;
   logic                  in_region;
   logic [4:0]            cutoff_nxt;
   logic                  row_edge_nxt;
   logic                  sub_wrap;
   logic                  px_in;

   function automatic logic [8:0] lfsr_step(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   always_comb begin
      in_region    = (lyr.vcount >= TOP);
      d            = lyr.vcount - TOP;
      rows         = d >> ROW_H_LOG2;
      roff         = d[ROW_H_LOG2-1:0];
      cutoff_nxt   = 5'd0;
      row_edge_nxt = 1'b0;
      if (in_region) begin
         cutoff_nxt   = (rows > 10'd16) ? 5'd16 : rows[4:0];
         row_edge_nxt = (roff == '0) | (&roff);
      end
   end

   // With SPEED_LOG2 == 0 the sub-counter is vestigial and every frame scrolls.
   assign sub_wrap = (SPEED_LOG2 == 0) || (&sub);
   assign px_in    = ({1'b0, lfsr[3:0]} < cutoff);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= SEED;
         lfsr_b   <= SEED;
         col      <= '0;
         col_b    <= '0;
         sub      <= '0;
         cutoff   <= 5'd0;
         row_edge <= 1'b0;
         hit_q    <= 1'b0;
         border_q <= 1'b0;
      end else begin
         hit_q    <= 1'b0;
         border_q <= 1'b0;
         if (lyr.line_start) begin
            // Reload uses the pre-scroll origin; a scroll step shows from the next line.
            lfsr     <= lfsr_b;
            col      <= col_b;
            cutoff   <= cutoff_nxt;
            row_edge <= row_edge_nxt;
            if (lyr.frame_start) begin
               sub <= sub + SUB_W'(1);
               if (sub_wrap) begin
                  col_b <= col_b + COL_W_LOG2'(1);
                  if (&col_b) begin
                     lfsr_b <= lfsr_step(lfsr_b);
                  end
               end
            end
         end else if (lyr.visible) begin
            col <= col + COL_W_LOG2'(1);
            if (&col) begin
               lfsr <= lfsr_step(lfsr);
            end
            hit_q    <= px_in;
            border_q <= px_in & ((col == '0) | row_edge);
         end
      end
   end

   assign lyr.hit    = hit_q;
   assign lyr.border = border_q;

endmodule

// File: tb/tb_skyline_layer.sv
// Bench for skyline_layer: two differently parameterised layers driven by the same raster
// stream, compared every cycle against a position-based model of the skyline.
module tb_skyline_layer;

   localparam int C0_CW = 3, C0_RH = 4, C0_TOP = 112, C0_SL = 0;
   localparam int C1_CW = 2, C1_RH = 3, C1_TOP = 200, C1_SL = 2;
   localparam logic [8:0] C0_SEED = 9'h1FF;
   localparam logic [8:0] C1_SEED = 9'h0A5;

   logic clk = 1'b0;
   logic rst;

   skyline_layer_if if0 ();
   skyline_layer_if if1 ();

   skyline_layer #(.COL_W_LOG2(C0_CW), .ROW_H_LOG2(C0_RH), .TOP_LINE(C0_TOP),
                   .SPEED_LOG2(C0_SL), .SEED(C0_SEED))
      dut0 (.clk(clk), .rst(rst), .lyr(if0));

   skyline_layer #(.COL_W_LOG2(C1_CW), .ROW_H_LOG2(C1_RH), .TOP_LINE(C1_TOP),
                   .SPEED_LOG2(C1_SL), .SEED(C1_SEED))
      dut1 (.clk(clk), .rst(rst), .lyr(if1));

   always #5 clk = ~clk;

   int cw  [2] = '{C0_CW, C1_CW};
   int rh  [2] = '{C0_RH, C1_RH};
   int top [2] = '{C0_TOP, C1_TOP};
   int sl  [2] = '{C0_SL, C1_SL};

   // Column heights by column index: entry n is the generator after n steps from its seed.
   logic [8:0] seq [2][511];

   int frames;
   int base  [2];
   int pix   [2];
   int cut   [2];
   bit redge [2];
   int n_chk;
   int n_fail;

   task automatic chk(input string tag, input logic obs, input bit exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic step(input bit v, input bit ls, input bit fs, input int vc, input bit r);
      bit eh [2];
      bit eb [2];
      int x, h, dd, ro;
      if0.visible = v;  if0.line_start = ls;  if0.frame_start = fs;  if0.vcount = 10'(vc);
      if1.visible = v;  if1.line_start = ls;  if1.frame_start = fs;  if1.vcount = 10'(vc);
      rst = r;
      for (int k = 0; k < 2; k++) begin
         eh[k] = 1'b0;
         eb[k] = 1'b0;
         if (r) begin
            base[k] = 0; pix[k] = 0; cut[k] = 0; redge[k] = 1'b0;
         end else if (ls) begin
            base[k] = frames >> sl[k];
            pix[k]  = 0;
            if (vc < top[k]) begin
               cut[k] = 0; redge[k] = 1'b0;
            end else begin
               dd       = vc - top[k];
               cut[k]   = (dd / (1 << rh[k]) > 16) ? 16 : dd / (1 << rh[k]);
               ro       = dd % (1 << rh[k]);
               redge[k] = (ro == 0) || (ro == (1 << rh[k]) - 1);
            end
         end else if (v) begin
            x      = base[k] + pix[k];
            h      = int'(seq[k][(x >> cw[k]) % 511] & 9'h00F);
            eh[k]  = (h < cut[k]);
            eb[k]  = eh[k] && ((x % (1 << cw[k]) == 0) || redge[k]);
            pix[k] = pix[k] + 1;
         end
      end
      if (r) frames = 0;
      else if (ls && fs) frames++;
      @(negedge clk);
      chk("l0_hit",    if0.hit,    eh[0]);
      chk("l0_border", if0.border, eb[0]);
      chk("l1_hit",    if1.hit,    eh[1]);
      chk("l1_border", if1.border, eb[1]);
   endtask

   task automatic line(input int vc, input bit fs, input int n);
      step(1'b0, 1'b1, fs, vc, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      logic [8:0] s;
      n_chk  = 0;
      n_fail = 0;
      frames = 0;
      for (int k = 0; k < 2; k++) begin
         s = (k == 0) ? C0_SEED : C1_SEED;
         for (int n = 0; n < 511; n++) begin
            seq[k][n] = s;
            s = {s[7:0], s[8] ^ s[4]};
         end
         base[k] = 0; pix[k] = 0; cut[k] = 0; redge[k] = 1'b0;
      end

      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);

      line(479, 1'b0, 24);
      line(478, 1'b0, 24);
      line(100, 1'b0, 640);
      line(341, 1'b0, 24);
      line(352, 1'b0, 24);

      line(479, 1'b1, 24);
      line(478, 1'b0, 24);
      for (int f = 0; f < 7; f++) step(1'b0, 1'b1, 1'b1, 478, 1'b0);
      line(478, 1'b0, 24);
      line(300, 1'b1, 24);
      line(300, 1'b1, 24);

      // Line start landing on an active pixel, then a reset mid-line.
      line(478, 1'b0, 10);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 478, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      line(479, 1'b0, 24);

      // frame_start without line_start must be ignored.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0, 1'b0);
      line(479, 1'b0, 24);

      for (int ln = 0; ln < 220; ln++) begin
         int vc, n;
         bit fs;
         vc = $urandom_range(0, 1023);
         fs = ($urandom_range(0, 2) == 0);
         n  = $urandom_range(8, 64);
         step(1'b0, 1'b1, fs, vc, 1'b0);
         for (int i = 0; i < n; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       step(1'b1, 1'b1, 1'b0, $urandom_range(0, 1023), 1'b0);
            else if (sel < 3)  step(1'b1, 1'b0, 1'b0, 0, 1'b1);
            else if (sel < 12) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
            else               step(1'b1, 1'b0, 1'b0, 0, 1'b0);
         end
      end

      // Long scroll run so the column origin wraps the full generator period.
      for (int f = 0; f < 4200; f++) begin
         step(1'b0, 1'b1, 1'b1, 479, 1'b0);
         if (f % 700 == 0) begin
            for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
         end
      end
      line(479, 1'b0, 40);
      line(352, 1'b0, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
